fir_decimator: RTL and testbench
================================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DECIM, default 4: samples per output block; legal values 2, 4, 8.
REQ-002 Parameter FIFO_DEPTH, default 4: result buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 din  input  10  unsigned filtered sample from the FIR stage (its dataout).
REQ-006 din_valid  input  1  din carries a new sample this cycle; always accepted, no backpressure upstream.
REQ-007 dout  output  10  unsigned block mean, head of result FIFO.
REQ-008 dout_valid  output  1  dout holds a valid result.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 overflow  output  1  sticky; a block result was dropped because the FIFO was full.
REQ-011 fill  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 Accumulator width SHALL be 10+log2(DECIM) bits, so no internal overflow (8 x 1023 = 8184 fits 13 bits).
REQ-013 Phase counter SHALL count accepted samples 0..DECIM-1 and wrap to 0 on the edge accepting the DECIM-th sample.
REQ-014 Control FSM states: ACCUM (phase < DECIM-1) and LAST (phase = DECIM-1); ACCUM->LAST on phase reaching DECIM-1; LAST->ACCUM on an accepted sample.
REQ-015 On the edge accepting sample k with k < DECIM, the accumulator SHALL add din; cycles with din_valid=0 SHALL leave all datapath state unchanged.
REQ-016 On the edge accepting the DECIM-th sample, the result (acc+din) >> log2(DECIM), truncated, SHALL be pushed and the accumulator cleared to 0.
REQ-017 dout_valid SHALL be high in the cycle immediately after the pushing edge when the FIFO was empty; latency 1 cycle from the last sample.
REQ-018 A pop occurs on an edge with dout_valid=1 and dout_ready=1; dout SHALL present the next entry in the following cycle, in FIFO order.
REQ-019 FIFO full with push and pop on the same edge: both SHALL occur; fill unchanged; no overflow.
REQ-020 FIFO full with push and no pop: the result SHALL be dropped, FIFO contents unchanged, overflow set and held until reset.
REQ-021 FIFO empty with dout_ready=1: no pop; fill stays 0.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fill SHALL range 0..FIFO_DEPTH.
REQ-023 dout SHALL be 0 whenever dout_valid=0.

Reset
REQ-024 On rst assertion, asynchronously: accumulator=0, phase=0, FSM=ACCUM, FIFO pointers=0, fill=0, dout=0, dout_valid=0, overflow=0.
REQ-025 Reset mid-block SHALL discard the partial sum; the first block after release starts with the first accepted sample.
REQ-026 Samples presented while rst=1 SHALL be ignored.

Structure
REQ-027 Shared package fir_pkg SHALL hold FIR_OUT_W=10, DEFAULT_DECIM=4, DEFAULT_FIFO_DEPTH=4 and the FSM state encoding.
REQ-028 The result buffer SHALL be a separate sub-module fir_sync_fifo with push/pop/full/empty/count ports; accumulation and FSM stay in fir_decimator.

Verification
REQ-029 DECIM=4, din_valid=1 with 5, 10, 12, 15 -> dout=10 (42>>2), dout_valid high one cycle after the edge accepting 15.
REQ-030 Gapped input 16, gap, 16, gap, 16, 16 with dout_ready=1 -> single result 16; phase holds during gaps.
REQ-031 Four samples of 1023 -> dout=1023, no wrap; four samples of 3 -> dout=3.
REQ-032 dout_ready=0, five complete blocks of 8 -> fill=4, overflow=1, fifth result dropped; then dout_ready=1 -> four 8s drained, overflow stays 1.
REQ-033 FIFO full plus block completion on the same edge as a pop -> fill stays 4, overflow stays 0, new result appears last.
REQ-034 Two samples of 100, rst pulse, then four samples of 8 -> single result 8; all outputs 0 during reset.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimator block and its result FIFO.
// Holds the FIR output sample width, the default decimation/FIFO sizes
// and the decimator control FSM state encoding.
package fir_pkg;

  // Width of a filtered sample coming out of the FIR stage
  localparam int FIR_OUT_W          = 10;
  // Samples averaged per output block
  localparam int DEFAULT_DECIM      = 4;
  // Entries in the result FIFO
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // ST_ACCUM: still collecting, ST_LAST: the next accepted sample closes the block
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock result FIFO for the decimator: push/pop on rising edge.
// Latency: a push into an empty FIFO is visible at pop_data one cycle later.
// Backpressure: a push while full is accepted only if a pop happens on the same edge.
// Ports: clk/rst (async active-high); push/push_data write side;
//        pop/pop_data read side (pop_data is the head, 0 when empty);
//        full/empty/count occupancy status.
module fir_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still takes a push when the head leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to 0 when nothing is stored
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Block-mean decimator: averages every DECIM accepted samples into one result.
// Latency: result is at dout one cycle after the edge accepting the last sample.
// Backpressure: none upstream; results queue in a FIFO, dropped (sticky overflow) when full.
// Ports: clk/rst (async active-high); din/din_valid sample input;
//        dout/dout_valid/dout_ready result output; overflow sticky drop flag;
//        fill current result FIFO occupancy.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM      = DEFAULT_DECIM,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIR_OUT_W-1:0]          din,
  input  logic                          din_valid,
  output logic [FIR_OUT_W-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = FIR_OUT_W + SHIFT;
  localparam int PH_W  = SHIFT;

  localparam logic [PH_W-1:0] PH_MAX = PH_W'(DECIM - 1);
  // Phase value whose accepted sample moves the FSM into ST_LAST
  localparam logic [PH_W-1:0] PH_PRE = PH_W'(DECIM - 2);

  dec_state_t           state;
  dec_state_t           state_nxt;
  logic [PH_W-1:0]      phase;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     sum;
  logic [FIR_OUT_W-1:0] result;
  logic                 push_req;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Wide enough for DECIM full-scale samples, so the sum never wraps
  assign sum    = acc + ACC_W'(din);
  assign result = sum[ACC_W-1:SHIFT];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (din_valid && (phase == PH_PRE)) state_nxt = ST_LAST;
      ST_LAST:  if (din_valid)                      state_nxt = ST_ACCUM;
      default:                                      state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    if ((state == ST_LAST) && din_valid) begin
      push_req = 1'b1;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      acc   <= '0;
    end else if (din_valid) begin
      phase <= (phase == PH_MAX) ? '0 : phase + PH_W'(1);
      acc   <= push_req ? '0 : sum;
    end
  end

  // Full FIFO implies non-empty, so dout_ready alone decides whether a slot frees up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !dout_ready) begin
      overflow <= 1'b1;
    end
  end

  // ---------------- result buffer ----------------
  fir_sync_fifo #(
    .W     (FIR_OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (result),
    .pop       (dout_ready),
    .pop_data  (dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill)
  );

  assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       din_valid;
  logic [9:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overflow;
  logic [2:0] fill;

  int n_cmp;
  int n_bad;

  fir_decimator #(
    .DECIM      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .fill       (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       rdy;
    logic       edv;
    int         ed;
    int         efill;
    logic       eov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input int d, input logic rdy,
                              input logic edv, input int ed, input int efill,
                              input logic eov);
    vec_t r;
    r.v = v; r.d = 10'(d); r.rdy = rdy;
    r.edv = edv; r.ed = ed; r.efill = efill; r.eov = eov;
    tbl.push_back(r);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic edv, input int ed,
                     input int efill, input logic eov);
    cmp({tag, " dout_valid"}, int'(dout_valid), int'(edv));
    cmp({tag, " dout"},       int'(dout),       ed);
    cmp({tag, " fill"},       int'(fill),       efill);
    cmp({tag, " overflow"},   int'(overflow),   int'(eov));
  endtask

  // Drive one cycle of inputs, let the edge commit, sample just after it
  task automatic step(input logic v, input int d, input logic rdy);
    @(negedge clk);
    din_valid  = v;
    din        = 10'(d);
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic block(input int d, input logic rdy);
    for (int k = 0; k < 4; k++) step(1'b1, d, rdy);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table: basic mean, gapped input, boundary values ----
    add(1, 5,  1, 0, 0, 0, 0);
    add(1, 10, 1, 0, 0, 0, 0);
    add(1, 12, 1, 0, 0, 0, 0);
    add(1, 15, 1, 1, 10, 1, 0);   // 42>>2
    add(0, 0,  1, 0, 0, 0, 0);    // popped
    add(1, 16, 1, 0, 0, 0, 0);
    add(0, 99, 1, 0, 0, 0, 0);    // gap: phase holds
    add(1, 16, 1, 0, 0, 0, 0);
    add(0, 99, 1, 0, 0, 0, 0);
    add(1, 16, 1, 0, 0, 0, 0);
    add(1, 16, 1, 1, 16, 1, 0);
    add(0, 0,  1, 0, 0, 0, 0);
    add(1, 1023, 1, 0, 0, 0, 0);
    add(1, 1023, 1, 0, 0, 0, 0);
    add(1, 1023, 1, 0, 0, 0, 0);
    add(1, 1023, 1, 1, 1023, 1, 0);
    add(1, 3, 1, 0, 0, 0, 0);     // pop of 1023 and first 3 on the same edge
    add(1, 3, 1, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0);
    add(1, 3, 1, 1, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, int'(tbl[i].d), tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].edv, tbl[i].ed, tbl[i].efill, tbl[i].eov);
    end

    // ---- overflow: five blocks of 8 with no consumer ----
    for (int b = 0; b < 4; b++) block(8, 1'b0);
    chk("ovf four blocks", 1'b1, 8, 4, 1'b0);
    block(8, 1'b0);
    chk("ovf fifth dropped", 1'b1, 8, 4, 1'b1);
    for (int n = 3; n >= 0; n--) begin
      step(1'b0, 0, 1'b1);
      chk($sformatf("ovf drain fill%0d", n), (n != 0), (n != 0) ? 8 : 0, n, 1'b1);
    end
    step(1'b0, 0, 1'b1);
    chk("empty with ready", 1'b0, 0, 0, 1'b1);

    // ---- reset mid-block with a queued result ----
    block(40, 1'b0);
    step(1'b1, 100, 1'b0);
    step(1'b1, 100, 1'b0);
    chk("pre reset", 1'b1, 40, 1, 1'b1);
    @(negedge clk);
    din_valid = 1'b1; din = 10'd100;
    #2 rst = 1'b1;
    #1 chk("async reset", 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("held reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    step(1'b1, 8, 1'b0);
    step(1'b1, 8, 1'b0);
    step(1'b1, 8, 1'b0);
    chk("post reset partial", 1'b0, 0, 0, 1'b0);
    step(1'b1, 8, 1'b0);
    chk("post reset block", 1'b1, 8, 1, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("post reset pop", 1'b0, 0, 0, 1'b0);

    // ---- full FIFO: push and pop on the same edge ----
    block(4, 1'b0);
    block(8, 1'b0);
    block(12, 1'b0);
    block(16, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 20, 1'b0);
    chk("full before swap", 1'b1, 4, 4, 1'b0);
    step(1'b1, 20, 1'b1);
    chk("swap", 1'b1, 8, 4, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("drain 12", 1'b1, 12, 3, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("drain 16", 1'b1, 16, 2, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("drain 20", 1'b1, 20, 1, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("drain empty", 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
